// File: rtl/shift_register_nbit.sv
// N-bit data-path register with single-cycle parallel load and multi-cycle
// shift/rotate operations driven by a start/busy/done handshake.
module shift_register_nbit #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] inp,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [AMT_W-1:0] amount,
   input  logic             sin,
   output logic [WIDTH-1:0] Q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic [AMT_W-1:0]   r_count;
   logic [AMT_W-1:0]   w_nextCount;
   logic [1:0]         r_mode;
   logic [1:0]         w_nextMode;
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   w_nextQ;
   logic               r_sout;
   logic               w_nextSout;
   logic               r_busy;
   logic               w_nextBusy;
   logic               r_done;
   logic               w_nextDone;
   logic [WIDTH-1:0]   w_shiftQ;
   logic               w_shiftOut;

   always_comb begin
      w_shiftQ   = r_q;
      w_shiftOut = r_sout;
      case (r_mode)
         2'b00: begin
            w_shiftQ   = {r_q[WIDTH-2:0], sin};
            w_shiftOut = r_q[WIDTH-1];
         end
         2'b01: begin
            w_shiftQ   = {sin, r_q[WIDTH-1:1]};
            w_shiftOut = r_q[0];
         end
         2'b10: begin
            w_shiftQ   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            w_shiftOut = r_q[0];
         end
         default: begin
            w_shiftQ   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            w_shiftOut = r_q[WIDTH-1];
         end
      endcase
   end

   // Load beats start in IDLE; everything on the inputs is ignored while shifting.
   always_comb begin
      w_nextState = r_state;
      w_nextCount = r_count;
      w_nextMode  = r_mode;
      w_nextQ     = r_q;
      w_nextSout  = r_sout;
      w_nextBusy  = r_busy;
      w_nextDone  = 1'b0;
      case (r_state)
         IDLE: begin
            if (load) begin
               w_nextQ = inp;
            end else if (start) begin
               if (amount == '0) begin
                  w_nextDone = 1'b1;
               end else begin
                  w_nextMode  = mode;
                  w_nextCount = amount;
                  w_nextBusy  = 1'b1;
                  w_nextState = SHIFT;
               end
            end
         end
         SHIFT: begin
            w_nextQ     = w_shiftQ;
            w_nextSout  = w_shiftOut;
            w_nextCount = r_count - AMT_W'(1);
            if (r_count == AMT_W'(1)) begin
               w_nextState = IDLE;
               w_nextBusy  = 1'b0;
               w_nextDone  = 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextBusy  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= IDLE;
         r_count <= '0;
         r_mode  <= '0;
         r_q     <= '0;
         r_sout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_count <= w_nextCount;
         r_mode  <= w_nextMode;
         r_q     <= w_nextQ;
         r_sout  <= w_nextSout;
         r_busy  <= w_nextBusy;
         r_done  <= w_nextDone;
      end
   end

   assign Q    = r_q;
   assign sout = r_sout;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_shift_register_nbit.sv
// Randomised scoreboard bench for shift_register_nbit: a driver pushes expected
// completion results, a monitor pops and compares them on every done pulse.
module tb_shift_register_nbit;

   localparam int W = 8;
   localparam int A = 4;

   logic         clk;
   logic         clr;
   logic         load;
   logic [W-1:0] inp;
   logic         start;
   logic [1:0]   mode;
   logic [A-1:0] amount;
   logic         sin;
   logic [W-1:0] Q;
   logic         sout;
   logic         busy;
   logic         done;

   typedef struct {
      logic [W-1:0] q;
      logic         so;
      int           cyc;
   } exp_t;

   exp_t         expQ[$];
   int           checks = 0;
   int           errors = 0;
   int           busyCount = 0;
   logic [W-1:0] modelQ = '0;
   logic         modelSout = 1'b0;
   logic         sinSeq[16];

   shift_register_nbit #(.WIDTH(W), .AMT_W(A)) dut (
      .clk(clk), .clr(clr), .load(load), .inp(inp), .start(start),
      .mode(mode), .amount(amount), .sin(sin), .Q(Q), .sout(sout),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: whole operation computed from plain arithmetic on integers.
   task automatic modelOp(input logic [1:0] m, input int k);
      int q;
      int so;
      int r;
      logic signed [W-1:0] sq;
      q  = int'(modelQ);
      so = int'(modelSout);
      if (k > 0) begin
         case (m)
            2'd0: for (int i = 0; i < k; i++) begin
               so = (q >> (W - 1)) & 1;
               q  = ((q * 2) + int'(sinSeq[i])) % (1 << W);
            end
            2'd1: for (int i = 0; i < k; i++) begin
               so = q & 1;
               q  = (q / 2) + (int'(sinSeq[i]) << (W - 1));
            end
            2'd2: begin
               so = (k - 1 < W) ? ((q >> (k - 1)) & 1) : ((q >> (W - 1)) & 1);
               sq = W'(q);
               sq = sq >>> k;
               q  = int'(W'(sq));
            end
            default: begin
               r  = k % W;
               q  = ((q << r) | (q >> (W - r))) & ((1 << W) - 1);
               so = q & 1;
            end
         endcase
      end
      modelQ    = W'(q);
      modelSout = so[0];
   endtask

   task automatic applyStimulus(input logic [1:0] m, input int k, input bit randSin,
                                input logic sinVal, input bit garbage);
      exp_t e;
      for (int i = 0; i < 16; i++) sinSeq[i] = randSin ? logic'($urandom_range(0, 1)) : sinVal;
      modelOp(m, k);
      e.q   = modelQ;
      e.so  = modelSout;
      e.cyc = k;
      expQ.push_back(e);
      load   = 1'b0;
      start  = 1'b1;
      mode   = m;
      amount = A'(k);
      @(posedge clk); #1;
      start = 1'b0;
      if (k > 0) checkOutput("busy_after_start", 32'(busy), 32'd1);
      else begin
         checkOutput("zero_amt_busy", 32'(busy), 32'd0);
         checkOutput("zero_amt_done", 32'(done), 32'd1);
      end
      for (int i = 0; i < k; i++) begin
         sin = sinSeq[i];
         if (garbage) begin
            load   = logic'($urandom_range(0, 1));
            inp    = 8'hFF;
            start  = logic'($urandom_range(0, 1));
            mode   = 2'($urandom);
            amount = A'($urandom);
         end
         @(posedge clk); #1;
      end
      load  = 1'b0;
      start = 1'b0;
   endtask

   task automatic doLoad(input logic [W-1:0] v, input logic withStart);
      load  = 1'b1;
      inp   = v;
      start = withStart;
      mode  = 2'($urandom);
      amount = A'($urandom_range(1, 15));
      @(posedge clk); #1;
      load  = 1'b0;
      start = 1'b0;
      modelQ = v;
      checkOutput("load_q", 32'(Q), 32'(v));
      checkOutput("load_busy", 32'(busy), 32'd0);
      checkOutput("load_done", 32'(done), 32'd0);
   endtask

   // Monitor: counts busy cycles and scores each completion pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!clr) busyCount = 0;
         else begin
            if (busy) busyCount++;
            if (done) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_done: got done=1, expected no pending operation at %0t", $time);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("done_q", 32'(Q), 32'(e.q));
                  checkOutput("done_sout", 32'(sout), 32'(e.so));
                  checkOutput("busy_cycles", 32'(busyCount), 32'(e.cyc));
               end
               busyCount = 0;
            end
         end
      end
   end

   initial begin
      clr = 1'b0; load = 1'b0; inp = '0; start = 1'b0; mode = '0; amount = '0; sin = 1'b0;
      #3;
      checkOutput("reset_q", 32'(Q), 32'd0);
      checkOutput("reset_sout", 32'(sout), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      #4 clr = 1'b1;
      @(posedge clk); #1;

      doLoad(8'hA5, 1'b0);
      applyStimulus(2'b00, 3, 1'b0, 1'b0, 1'b0);
      checkOutput("sll_q", 32'(Q), 32'h28);
      checkOutput("sll_sout", 32'(sout), 32'd1);
      applyStimulus(2'b01, 0, 1'b0, 1'b0, 1'b0);
      checkOutput("zero_amt_q", 32'(Q), 32'h28);

      doLoad(8'h96, 1'b0);
      applyStimulus(2'b10, 2, 1'b0, 1'b0, 1'b1);
      checkOutput("sra_q", 32'(Q), 32'hE5);
      checkOutput("sra_sout", 32'(sout), 32'd1);

      doLoad(8'h0F, 1'b0);
      applyStimulus(2'b01, 4, 1'b0, 1'b1, 1'b1);
      checkOutput("srl_q", 32'(Q), 32'hF0);
      checkOutput("srl_sout", 32'(sout), 32'd1);
      applyStimulus(2'b11, 1, 1'b0, 1'b0, 1'b0);
      checkOutput("b2b_rol_q", 32'(Q), 32'hE1);

      doLoad(8'h81, 1'b0);
      applyStimulus(2'b11, 9, 1'b0, 1'b0, 1'b0);
      checkOutput("rol9_q", 32'(Q), 32'h03);
      checkOutput("rol9_sout", 32'(sout), 32'd1);

      doLoad(8'h3C, 1'b1);
      checkOutput("load_keeps_sout", 32'(sout), 32'd1);

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) == 0) doLoad(W'($urandom), logic'($urandom_range(0, 1)));
         else applyStimulus(2'($urandom), int'($urandom_range(0, 15)), 1'b1, 1'b0,
                            bit'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) begin
            sin = logic'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      repeat (2) @(posedge clk);
      #1;

      doLoad(8'h5A, 1'b0);
      start = 1'b1; mode = 2'b11; amount = 4'd8;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 clr = 1'b0;
      #1;
      checkOutput("midreset_q", 32'(Q), 32'd0);
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_done", 32'(done), 32'd0);
      checkOutput("midreset_sout", 32'(sout), 32'd0);
      #3 clr = 1'b1;
      modelQ = '0;
      modelSout = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      checkOutput("post_reset_busy", 32'(busy), 32'd0);
      checkOutput("post_reset_q", 32'(Q), 32'd0);
      checkOutput("pending_ops", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_register_nbit.md
Name: shift_register_nbit

Overview:
- Parametrised successor of the team's N-bit load/clear register.
- Adds four multi-cycle shift/rotate modes and serial fill/serial out.
- Shift operations run over several cycles under a start/busy/done handshake; parallel load remains single-cycle.
- Used as a configurable data-path register wherever the design needs to hold, shift or rotate an N-bit word one bit per clock.

Parameters:
WIDTH, 8, data width of inp and Q (must be >= 2)
AMT_W, 4, width of the shift-amount field; amounts 0 .. 2^AMT_W-1 are legal

Ports:
clk  input  1  system clock; all state updates on its rising edge
clr  input  1  asynchronous active-low reset
load  input  1  parallel load request, honoured only in IDLE
inp  input  WIDTH  parallel load data
start  input  1  one-cycle request to begin a shift operation, honoured only in IDLE
mode  input  2  operation: 00 shift left logical, 01 shift right logical, 10 shift right arithmetic, 11 rotate left
amount  input  AMT_W  number of single-bit shifts to perform
sin  input  1  serial fill bit for modes 00/01
Q  output  WIDTH  register contents
sout  output  1  bit shifted out by the most recent shift
busy  output  1  high while a shift operation is in progress
done  output  1  one-cycle pulse on completion of a start request

Behaviour:
- Reset (clr=0, asynchronous, any state, including mid-operation):
  - Q=0, sout=0, busy=0, done=0, internal count=0, state=IDLE.
  - Any in-flight operation is aborted with no completion pulse.
- States: IDLE and SHIFT.
- IDLE, load=1:
  - Q<=inp on the next edge.
  - load takes priority over start; a coincident start is dropped and no done is issued.
  - sout is unchanged.
- IDLE, start=1, load=0, amount=0:
  - No shift; Q unchanged; busy stays 0.
  - done=1 for the cycle after the edge.
- IDLE, start=1, load=0, amount=k>0, on edge E0:
  - Latch mode and k into internal registers; Q unchanged.
  - busy=1 and state=SHIFT after E0.
- SHIFT: at each edge E1..Ek, perform one shift on Q and decrement the count.
  - Mode 00: Q<={Q[W-2:0],sin}, sout<=Q[W-1].
  - Mode 01: Q<={sin,Q[W-1:1]}, sout<=Q[0].
  - Mode 10: Q<={Q[W-1],Q[W-1:1]}, sout<=Q[0].
  - Mode 11: Q<={Q[W-2:0],Q[W-1]}, sout<=Q[W-1].
- sin is sampled live at each shift edge, not latched at start.
- Completion:
  - At edge Ek: state<=IDLE, busy<=0, done<=1.
  - done drops at E(k+1).
  - busy is high for exactly k cycles; final Q is visible in the cycle done is high.
- While busy:
  - load, start, inp, mode and amount are ignored; no queuing.
  - Changes to mode or amount inputs do not affect the latched operation.
- done cycle: state is already IDLE, so a start or load in that cycle is accepted normally (back-to-back operations).
- amount >= WIDTH: all k single shifts are still performed.
  - Logical modes: Q ends filled with the sin history.
  - Arithmetic mode: Q ends as all sign bits.
  - Rotate: net rotation is k mod WIDTH.
- Outside shift edges sout holds its value; load does not change it.
- No combinational paths from inputs to outputs; all outputs are registered.

Test Plan:
- Reset during activity: clr=0 mid-shift (Q non-zero, busy=1) -> Q=0, busy=0, done=0, sout=0 immediately (before next clk edge); no done pulse after clr released.
- Load then SLL: load inp=0xA5; start mode=00 amount=3 sin=0 -> busy high exactly 3 cycles, then Q=0x28, sout=1, done high 1 cycle.
- SRA: Q=0x96; start mode=10 amount=2 -> Q=0xE5, sout=1, done after 2 busy cycles. SRL variant: Q=0x0F, sin=1, mode=01, amount=4 -> Q=0xF0, sout=1.
- Rotate overflow: Q=0x81; start mode=11 amount=9 -> busy 9 cycles, Q=0x03, sout=1.
- Zero amount and priority:
  - start amount=0 -> done next cycle, busy never high, Q unchanged.
  - load=1 with start=1 in IDLE -> Q=inp, no busy, no done.
- Busy protection / back-to-back:
  - load=1 inp=0xFF and start pulses during busy -> ignored; final Q unaffected.
  - start asserted in the done cycle -> second operation accepted; busy rises the next cycle.
